xge_pkt_gen: RTL and testbench

- Traffic source for the 10G tester; drives the MAC transmit packet interface (pkt_tx_data/sop/eop/mod/val) of the MAC+PCS wrapper and obeys its pkt_tx_full backpressure.
- Builds Ethernet frames from latched config: DA/SA, EtherType, 16-bit sequence number, deterministic payload.
- MAC appends FCS, so frames are generated without FCS.
- Supports a programmed packet count or continuous mode, a programmable inter-packet gap, and TX packet/byte statistics.

---
 rtl/xge_pkt_gen_if.sv | 20 ++
 rtl/xge_pkt_gen.sv | 239 +++++++++++++++++++++++
 tb/tb_xge_pkt_gen.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/xge_pkt_gen_if.sv
// MAC transmit packet interface between the traffic generator and the MAC.
// The master drives frame words; the slave returns FIFO-full backpressure.
interface xge_pkt_gen_if;
    logic [63:0] pkt_tx_data;
    logic        pkt_tx_val;
    logic        pkt_tx_sop;
    logic        pkt_tx_eop;
    logic [2:0]  pkt_tx_mod;
    logic        pkt_tx_full;

    modport master (
        output pkt_tx_data, pkt_tx_val, pkt_tx_sop, pkt_tx_eop, pkt_tx_mod,
        input  pkt_tx_full
    );

    modport slave (
        input  pkt_tx_data, pkt_tx_val, pkt_tx_sop, pkt_tx_eop, pkt_tx_mod,
        output pkt_tx_full
    );
endinterface

// File: rtl/xge_pkt_gen.sv
// xge_pkt_gen: Ethernet frame source for the 10G tester (frames without FCS).
// Frame = {DA, SA, EtherType, seq} header words followed by payload words.
// Word emission is gated by pkt_tx_full; all state is held while full.
// Optional feature macro: XGE_PKT_GEN_PRBS_EN adds cfg_prbs, which selects a
// PRBS31 payload (x^31+x^28+1, 64 bits per word, reseeded at every sop).
module xge_pkt_gen #(
    parameter int MIN_LEN = 60,
    parameter int MAX_LEN = 9600
) (
    input  logic        clk_156,
    input  logic        async_reset,
    input  logic        start,
    input  logic        stop,
    input  logic [13:0] cfg_len,
    input  logic [31:0] cfg_pkt_num,
    input  logic [15:0] cfg_gap,
    input  logic [47:0] cfg_da,
    input  logic [47:0] cfg_sa,
    input  logic [15:0] cfg_etype,
`ifdef XGE_PKT_GEN_PRBS_EN
    input  logic        cfg_prbs,
`endif
    xge_pkt_gen_if.master tx,
    output logic        busy,
    output logic        done,
    output logic [31:0] tx_pkt_cnt,
    output logic [47:0] tx_byte_cnt
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HDR0    = 3'd1,
        HDR1    = 3'd2,
        PAYLOAD = 3'd3,
        GAP     = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t      state, state_d;

    logic [13:0] len_q;
    logic [11:0] words_q;
    logic [2:0]  mod_q;
    logic [31:0] pkt_num_q;
    logic [15:0] gap_q;
    logic [47:0] da_q;
    logic [47:0] sa_q;
    logic [15:0] etype_q;
    logic [15:0] seq_q;
    logic [11:0] idx_q;
    logic [15:0] gap_cnt_q;
    logic        stop_pend_q;

    logic [13:0] len_c;
    logic [14:0] len_round;
    logic        start_acc;
    logic        word_state;
    logic        fire;
    logic        is_last;
    logic        stop_any;
    logic        finish;
    logic [15:0] k16;
    logic [63:0] word;
    logic [63:0] keep;

`ifdef XGE_PKT_GEN_PRBS_EN
    localparam logic [30:0] PRBS_SEED = 31'h7FFF_FFFF;
    logic        prbs_q;
    logic [30:0] lfsr_q;
    logic [30:0] lfsr_next;
    logic [63:0] prbs_word;

    // Advance the PRBS31 generator by 64 bits; first generated bit lands in [63].
    always_comb begin
        lfsr_next = lfsr_q;
        prbs_word = '0;
        for (int i = 0; i < 64; i++) begin
            prbs_word = {prbs_word[62:0], lfsr_next[30] ^ lfsr_next[27]};
            lfsr_next = {lfsr_next[29:0], lfsr_next[30] ^ lfsr_next[27]};
        end
    end
`endif

    // Clamp the requested length and derive the word count for the latched config.
    always_comb begin
        len_c = cfg_len;
        if (cfg_len < 14'(MIN_LEN))
            len_c = 14'(MIN_LEN);
        else if (cfg_len > 14'(MAX_LEN))
            len_c = 14'(MAX_LEN);
        len_round = {1'b0, len_c} + 15'd7;
    end

    assign start_acc  = start && (state == IDLE || state == DONE);
    assign word_state = (state == HDR0) || (state == HDR1) || (state == PAYLOAD);
    assign fire       = word_state && !tx.pkt_tx_full;
    assign is_last    = (state == PAYLOAD) && (idx_q == words_q - 12'd1);
    assign stop_any   = stop_pend_q || stop;
    assign finish     = ((pkt_num_q != 32'd0) && (tx_pkt_cnt + 32'd1 == pkt_num_q)) || stop_any;
    assign k16        = {4'b0, idx_q};
    assign keep       = ~(64'hFFFF_FFFF_FFFF_FFFF >> {mod_q, 3'b000});

    // Select the word for the current state and zero the unused tail bytes of the eop word.
    always_comb begin
        word = '0;
        case (state)
            HDR0:    word = {da_q, sa_q[47:32]};
            HDR1:    word = {sa_q[31:0], etype_q, seq_q};
            PAYLOAD: begin
`ifdef XGE_PKT_GEN_PRBS_EN
                if (prbs_q)
                    word = prbs_word;
                else
                    word = {seq_q, k16, ~seq_q, ~k16};
`else
                word = {seq_q, k16, ~seq_q, ~k16};
`endif
            end
            default: word = '0;
        endcase
        if (is_last && mod_q != 3'd0)
            word = word & keep;
    end

    assign tx.pkt_tx_data = word;
    assign tx.pkt_tx_val  = fire;
    assign tx.pkt_tx_sop  = fire && (state == HDR0);
    assign tx.pkt_tx_eop  = fire && is_last;
    assign tx.pkt_tx_mod  = (fire && is_last) ? mod_q : 3'd0;
    assign busy           = word_state || (state == GAP);
    assign done           = (state == DONE);

    // State register.
    always_ff @(posedge clk_156 or posedge async_reset) begin
        if (async_reset)
            state <= IDLE;
        else
            state <= state_d;
    end

    // Next-state logic: header/payload advance only on emitted words, gap counts free-running.
    always_comb begin
        state_d = state;
        case (state)
            IDLE, DONE: if (start) state_d = HDR0;
            HDR0:       if (fire) state_d = HDR1;
            HDR1:       if (fire) state_d = PAYLOAD;
            PAYLOAD: begin
                if (fire && is_last) begin
                    if (finish)
                        state_d = DONE;
                    else if (gap_q == 16'd0)
                        state_d = HDR0;
                    else
                        state_d = GAP;
                end
            end
            GAP: begin
                if (stop_any)
                    state_d = DONE;
                else if (gap_cnt_q == 16'd0)
                    state_d = HDR0;
            end
            default: state_d = IDLE;
        endcase
    end

    // Config latch, word index, gap counter, sequence number and statistics.
    always_ff @(posedge clk_156 or posedge async_reset) begin
        if (async_reset) begin
            len_q       <= '0;
            words_q     <= '0;
            mod_q       <= '0;
            pkt_num_q   <= '0;
            gap_q       <= '0;
            da_q        <= '0;
            sa_q        <= '0;
            etype_q     <= '0;
            seq_q       <= '0;
            idx_q       <= '0;
            gap_cnt_q   <= '0;
            stop_pend_q <= 1'b0;
            tx_pkt_cnt  <= '0;
            tx_byte_cnt <= '0;
        end else if (start_acc) begin
            len_q       <= len_c;
            words_q     <= len_round[14:3];
            mod_q       <= len_c[2:0];
            pkt_num_q   <= cfg_pkt_num;
            gap_q       <= cfg_gap;
            da_q        <= cfg_da;
            sa_q        <= cfg_sa;
            etype_q     <= cfg_etype;
            seq_q       <= '0;
            idx_q       <= '0;
            gap_cnt_q   <= '0;
            stop_pend_q <= 1'b0;
            tx_pkt_cnt  <= '0;
            tx_byte_cnt <= '0;
        end else begin
            if (busy && stop)
                stop_pend_q <= 1'b1;
            if (fire) begin
                if (state == HDR0)
                    idx_q <= 12'd1;
                else if (state == HDR1)
                    idx_q <= 12'd2;
                else if (is_last) begin
                    idx_q       <= '0;
                    tx_pkt_cnt  <= tx_pkt_cnt + 32'd1;
                    tx_byte_cnt <= tx_byte_cnt + {34'b0, len_q};
                    seq_q       <= seq_q + 16'd1;
                    gap_cnt_q   <= gap_q - 16'd1;
                end else
                    idx_q <= idx_q + 12'd1;
            end
            if (state == GAP)
                gap_cnt_q <= gap_cnt_q - 16'd1;
        end
    end

`ifdef XGE_PKT_GEN_PRBS_EN
    // PRBS generator: reseeded on the sop word, advanced on each emitted payload word.
    always_ff @(posedge clk_156 or posedge async_reset) begin
        if (async_reset) begin
            prbs_q <= 1'b0;
            lfsr_q <= PRBS_SEED;
        end else if (start_acc) begin
            prbs_q <= cfg_prbs;
            lfsr_q <= PRBS_SEED;
        end else if (fire && state == HDR0) begin
            lfsr_q <= PRBS_SEED;
        end else if (fire && state == PAYLOAD) begin
            lfsr_q <= lfsr_next;
        end
    end
`endif

endmodule

// File: tb/tb_xge_pkt_gen.sv
// Scoreboard bench for xge_pkt_gen: expected words are built byte-by-byte from
// the frame layout when a run is started and compared as the DUT emits them.
`timescale 1ns/1ps
module tb_xge_pkt_gen;

    localparam logic [47:0] DA = 48'h0011_2233_4455;
    localparam logic [47:0] SA = 48'hAABB_CCDD_EEFF;
    localparam logic [15:0] ET = 16'h88B5;

    typedef struct {
        logic [63:0] d;
        logic        sop;
        logic        eop;
        logic [2:0]  mod;
    } exp_t;

    logic        clk_156 = 1'b0;
    logic        async_reset = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [13:0] cfg_len = '0;
    logic [31:0] cfg_pkt_num = '0;
    logic [15:0] cfg_gap = '0;
    logic [47:0] cfg_da = DA;
    logic [47:0] cfg_sa = SA;
    logic [15:0] cfg_etype = ET;
    logic        busy, done;
    logic [31:0] tx_pkt_cnt;
    logic [47:0] tx_byte_cnt;

    xge_pkt_gen_if tx_if ();

    xge_pkt_gen dut (
        .clk_156     (clk_156),
        .async_reset (async_reset),
        .start       (start),
        .stop        (stop),
        .cfg_len     (cfg_len),
        .cfg_pkt_num (cfg_pkt_num),
        .cfg_gap     (cfg_gap),
        .cfg_da      (cfg_da),
        .cfg_sa      (cfg_sa),
        .cfg_etype   (cfg_etype),
        .tx          (tx_if),
        .busy        (busy),
        .done        (done),
        .tx_pkt_cnt  (tx_pkt_cnt),
        .tx_byte_cnt (tx_byte_cnt)
    );

    always #3.2 clk_156 = ~clk_156;

    exp_t sb[$];
    int   nchk = 0;
    int   nbad = 0;
    int   nwords = 0;
    int   idle = 0;
    int   exp_gap = -1;
    bit   seen_eop = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nchk++;
        if (got !== exp) begin
            nbad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] byte_at(input int p, input int l, input logic [15:0] s);
        logic [63:0] w;
        logic [15:0] k;
        if (p >= l) return 8'h00;
        if (p < 6)  return DA[47 - 8*p -: 8];
        if (p < 12) return SA[47 - 8*(p-6) -: 8];
        if (p < 14) return ET[15 - 8*(p-12) -: 8];
        if (p < 16) return s[15 - 8*(p-14) -: 8];
        k = 16'(p / 8);
        w = {s, k, ~s, ~k};
        return w[63 - 8*(p % 8) -: 8];
    endfunction

    task automatic push_frame(input int len, input logic [15:0] s);
        int   l, nw;
        exp_t e;
        l  = (len < 60) ? 60 : ((len > 9600) ? 9600 : len);
        nw = (l + 7) / 8;
        for (int i = 0; i < nw; i++) begin
            for (int j = 0; j < 8; j++)
                e.d[63 - 8*j -: 8] = byte_at(8*i + j, l, s);
            e.sop = (i == 0);
            e.eop = (i == nw - 1);
            e.mod = (i == nw - 1) ? 3'(l % 8) : 3'd0;
            sb.push_back(e);
        end
    endtask

    task automatic kick(input logic [13:0] len, input logic [31:0] num, input logic [15:0] gap);
        @(posedge clk_156); #1;
        nwords = 0;
        seen_eop = 0;
        idle = 0;
        cfg_len = len;
        cfg_pkt_num = num;
        cfg_gap = gap;
        start = 1'b1;
        @(posedge clk_156); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk_156); #1;
            if (done) break;
        end
        chk("done", 64'(done), 64'd1);
    endtask

    task automatic wait_words(input int n, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk_156); #1;
            if (nwords >= n) break;
        end
        chk("word_wait", 64'(nwords >= n), 64'd1);
    endtask

    // Monitor: compare each emitted word against the scoreboard and measure eop->sop gaps.
    always @(negedge clk_156) begin
        exp_t e;
        if (!async_reset) begin
            if (tx_if.pkt_tx_full)
                chk("stall_val", 64'(tx_if.pkt_tx_val), 64'd0);
            if (tx_if.pkt_tx_val) begin
                nwords++;
                if (tx_if.pkt_tx_sop && exp_gap >= 0 && seen_eop)
                    chk("gap", 64'(idle), 64'(exp_gap));
                if (sb.size() == 0) begin
                    chk("extra_word", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("data", tx_if.pkt_tx_data, e.d);
                    chk("flags", {59'd0, tx_if.pkt_tx_sop, tx_if.pkt_tx_eop, tx_if.pkt_tx_mod},
                        {59'd0, e.sop, e.eop, e.mod});
                end
                if (tx_if.pkt_tx_eop) begin
                    seen_eop = 1;
                    idle = 0;
                end
            end else begin
                idle++;
            end
        end
    end

    initial begin
        tx_if.pkt_tx_full = 1'b0;
        repeat (3) @(posedge clk_156);
        #1;
        chk("rst_val", 64'(tx_if.pkt_tx_val), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_cnt", 64'(tx_pkt_cnt), 64'd0);
        async_reset = 1'b0;
        @(posedge clk_156); #1;
        chk("idle_done", 64'(done), 64'd0);

        // Single minimum-length frame.
        push_frame(60, 16'd0);
        kick(14'd60, 32'd1, 16'd0);
        wait_done(100);
        chk("t1_pkts", 64'(tx_pkt_cnt), 64'd1);
        chk("t1_bytes", 64'(tx_byte_cnt), 64'd60);
        chk("t1_words", 64'(nwords), 64'd8);
        chk("t1_sb", 64'(sb.size()), 64'd0);

        // Three frames with a 5-cycle gap.
        exp_gap = 5;
        for (int f = 0; f < 3; f++) push_frame(100, 16'(f));
        kick(14'd100, 32'd3, 16'd5);
        wait_done(200);
        chk("t2_pkts", 64'(tx_pkt_cnt), 64'd3);
        chk("t2_bytes", 64'(tx_byte_cnt), 64'd300);
        chk("t2_words", 64'(nwords), 64'd39);

        // Back-to-back frames with a 4-cycle stall on word 3.
        exp_gap = 0;
        for (int f = 0; f < 2; f++) push_frame(64, 16'(f));
        kick(14'd64, 32'd2, 16'd0);
        for (int i = 0; i < 50; i++) begin
            if (nwords >= 3) break;
            @(posedge clk_156); #1;
        end
        tx_if.pkt_tx_full = 1'b1;
        repeat (4) @(posedge clk_156);
        #1;
        tx_if.pkt_tx_full = 1'b0;
        wait_done(100);
        chk("t3_words", 64'(nwords), 64'd16);
        chk("t3_bytes", 64'(tx_byte_cnt), 64'd128);

        // Length clamping at both ends.
        exp_gap = -1;
        push_frame(20, 16'd0);
        kick(14'd20, 32'd1, 16'd0);
        wait_done(100);
        chk("t4_min_bytes", 64'(tx_byte_cnt), 64'd60);
        chk("t4_min_words", 64'(nwords), 64'd8);
        push_frame(16000, 16'd0);
        kick(14'd16000, 32'd1, 16'd0);
        wait_done(2000);
        chk("t4_max_bytes", 64'(tx_byte_cnt), 64'd9600);
        chk("t4_max_words", 64'(nwords), 64'd1200);

        // Continuous mode stopped during frame 5's payload.
        exp_gap = 2;
        for (int f = 0; f < 5; f++) push_frame(60, 16'(f));
        kick(14'd60, 32'd0, 16'd2);
        wait_words(36, 300);
        stop = 1'b1;
        @(posedge clk_156); #1;
        stop = 1'b0;
        wait_done(100);
        repeat (20) @(posedge clk_156);
        #1;
        chk("t5_pkts", 64'(tx_pkt_cnt), 64'd5);
        chk("t5_words", 64'(nwords), 64'd40);
        chk("t5_done", 64'(done), 64'd1);
        chk("t5_sb", 64'(sb.size()), 64'd0);

        // Asynchronous reset in the middle of a payload.
        exp_gap = -1;
        push_frame(100, 16'd0);
        kick(14'd100, 32'd1, 16'd0);
        wait_words(5, 100);
        async_reset = 1'b1;
        #1;
        chk("ar_val", 64'(tx_if.pkt_tx_val), 64'd0);
        chk("ar_sop_eop", {62'd0, tx_if.pkt_tx_sop, tx_if.pkt_tx_eop}, 64'd0);
        chk("ar_pkts", 64'(tx_pkt_cnt), 64'd0);
        chk("ar_bytes", 64'(tx_byte_cnt), 64'd0);
        chk("ar_busy", 64'(busy), 64'd0);
        repeat (2) @(posedge clk_156);
        #1;
        async_reset = 1'b0;
        sb.delete();
        push_frame(60, 16'd0);
        kick(14'd60, 32'd1, 16'd0);
        wait_done(100);
        chk("ar_restart_pkts", 64'(tx_pkt_cnt), 64'd1);
        chk("ar_restart_sb", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", nchk, nbad);
        $finish;
    end

endmodule
